// File: rtl/parity_frame_checker.sv
// Receive end of the XOR-parity link: deserialises DATA_BITS data bits (LSB first) plus a
// parity bit and delivers the word with a parity error flag. Optional macro: PARITY_ERR_COUNT_EN.
module parity_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic                 in_ready,
    input  logic                 in_abort,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [15:0]          err_count
`endif
);

    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic              ODD_BIT  = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PARITY  = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t                 state_q,    state_d;
    logic [IDX_W-1:0]       bit_idx_q,  bit_idx_d;
    logic                   acc_q,      acc_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic [DATA_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_err_q,  out_err_d;
    logic                   out_valid_q, out_valid_d;
    logic                   accept_s;
    logic                   handshake_s;

    function automatic logic parity_mismatch(input logic acc, input logic parity_bit);
        return (acc ^ parity_bit) != ODD_BIT;
    endfunction

    assign in_ready    = reset_n & ((state_q != ST_HOLD) | out_ready);
    assign accept_s    = in_valid & in_ready;
    assign handshake_s = out_valid_q & out_ready;
    assign out_data    = out_data_q;
    assign out_err     = out_err_q;
    assign out_valid   = out_valid_q;

    // Next-state logic: frame collection, parity check and output hold.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        acc_d       = acc_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_COLLECT: begin
                if (in_abort) begin
                    bit_idx_d = '0;
                    acc_d     = 1'b0;
                    shift_d   = '0;
                end else if (accept_s) begin
                    shift_d[bit_idx_q] = in_bit;
                    acc_d              = acc_q ^ in_bit;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_PARITY: begin
                if (in_abort) begin
                    bit_idx_d = '0;
                    acc_d     = 1'b0;
                    shift_d   = '0;
                    state_d   = ST_COLLECT;
                end else if (accept_s) begin
                    out_data_d  = shift_q;
                    out_err_d   = parity_mismatch(acc_q, in_bit);
                    out_valid_d = 1'b1;
                    acc_d       = 1'b0;
                    bit_idx_d   = '0;
                    state_d     = ST_HOLD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (handshake_s) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_COLLECT;
                end else begin
                    state_d = state_q;
                end
                // A bit accepted here implies the release handshake: it is bit 0 of the next frame.
                if (in_abort) begin
                    bit_idx_d = '0;
                    acc_d     = 1'b0;
                    shift_d   = '0;
                end else if (accept_s) begin
                    shift_d[bit_idx_q] = in_bit;
                    acc_d              = acc_q ^ in_bit;
                    bit_idx_d          = bit_idx_q + IDX_W'(1);
                end else begin
                    acc_d = acc_q;
                end
            end
            default: begin
                state_d     = ST_COLLECT;
                bit_idx_d   = '0;
                acc_d       = 1'b0;
                shift_d     = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_COLLECT;
            bit_idx_q   <= '0;
            acc_q       <= 1'b0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            acc_q       <= acc_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Saturating count of delivered words that failed the parity check.
    always_comb begin
        err_count_d = err_count_q;
        if (handshake_s && out_err_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
